// File: rtl/layer_bias_rx.sv
// Bias stream receiver: unpacks 64-bit beats (two biases each) into a per-layer
// bias buffer, flags stream-length errors and serves biases through a registered
// random-access read port.
module layer_bias_rx #(
  parameter int unsigned CH_NUM = 256,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                sclk,
  input  logic                s_rst,
  input  logic                load_start,
  input  logic [2*DATA_W-1:0] bias_data,
  input  logic                bias_valid,
  input  logic                bias_last,
  output logic                ready,
  output logic                bias_done,
  output logic                len_err,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

  // Beat index of the final beat of a full layer.
  localparam logic [ADDR_W-1:0] LastCnt = ADDR_W'(CH_NUM / 2 - 1);
  localparam logic [ADDR_W:0]   ChLimit = (ADDR_W + 1)'(CH_NUM);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
  logic                len_err_q, len_err_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0]   mem_q [CH_NUM];

  logic                beat_fire;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr_even;
  logic [ADDR_W-1:0]   wr_addr_odd;
  logic                rd_in_range;
  logic                at_last_cnt;

  // Handshake decode: ready comes straight from the state register.
  always_comb begin
    ready        = (state_q == StLoad);
    bias_done    = (state_q == StDone);
    len_err      = len_err_q;
    beat_fire    = bias_valid && ready;
    // A reset edge must not commit a beat that arrives alongside it.
    wr_en        = beat_fire && !s_rst;
    wr_addr_even = {word_cnt_q[ADDR_W-2:0], 1'b0};
    wr_addr_odd  = {word_cnt_q[ADDR_W-2:0], 1'b1};
    at_last_cnt  = (word_cnt_q == LastCnt);
  end

  // Load FSM next-state: counts beats and classifies how the stream ended.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    len_err_d  = len_err_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d    = StLoad;
          word_cnt_d = '0;
          len_err_d  = 1'b0;
        end
      end
      StLoad: begin
        // load_start is deliberately ignored here.
        if (beat_fire) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (bias_last || at_last_cnt) begin
            state_d = StDone;
            // Early last or missing last both end the load with an error.
            if (!(bias_last && at_last_cnt)) begin
              len_err_d = 1'b1;
            end
          end
        end
      end
      StDone: begin
        if (load_start) begin
          state_d    = StLoad;
          word_cnt_d = '0;
          len_err_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read port next-state: registered lookup, data held while idle.
  always_comb begin
    rd_in_range = ({1'b0, rd_addr} < ChLimit);
    rd_valid_d  = rd_en;
    rd_data_d   = rd_data_q;
    if (rd_en) begin
      // Sampled from the pre-write contents, so a same-edge write reads old data.
      rd_data_d = rd_in_range ? mem_q[rd_addr] : '0;
    end
  end

  // Control and read-port state, synchronous active-high reset.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      len_err_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_err_q  <= len_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Bias buffer: both halves of an accepted beat land in one edge; never cleared.
  always_ff @(posedge sclk) begin
    if (wr_en) begin
      mem_q[wr_addr_even] <= bias_data[DATA_W-1:0];
      mem_q[wr_addr_odd]  <= bias_data[2*DATA_W-1:DATA_W];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: doc/layer_bias_rx.md
Name: layer_bias_rx

Overview:
- Receiving end of the per-layer bias stream: 64-bit beats, each carrying two 32-bit signed biases, on a valid/ready/last handshake.
- Unpacks each beat into a CH_NUM-deep, 32-bit bias buffer. Detects stream-length errors.
- Serves biases to the convolution/accumulate stage through a registered random-access read port.
- Sits between the bias source (DMA or sim transmitter) and the layer's post-accumulate bias adder.

Parameters:
- CH_NUM, 256, number of output-channel biases per layer; must be even.
- DATA_W, 32, bias width; beat width is 2*DATA_W.
- ADDR_W, 8, read address width; equals clog2(CH_NUM).

Ports:
- sclk  input  1  system clock; all logic is on the rising edge.
- s_rst  input  1  synchronous, active-high reset.
- load_start  input  1  single-cycle pulse; arms a new bias load.
- bias_data  input  2*DATA_W  beat; [DATA_W-1:0] is the even channel, [2*DATA_W-1:DATA_W] is the odd channel.
- bias_valid  input  1  beat valid.
- bias_last  input  1  final beat of the layer.
- ready  output  1  receiver can accept a beat.
- bias_done  output  1  buffer is loaded; level signal.
- len_err  output  1  sticky; beat count does not equal CH_NUM/2.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  channel index.
- rd_data  output  DATA_W  bias for that channel; 1-cycle latency.
- rd_valid  output  1  rd_data is valid; 1-cycle latency.

Behaviour:
- Reset (s_rst=1 at a clock edge):
  - State goes to IDLE; word_cnt=0.
  - ready, bias_done, len_err, rd_valid are 0; rd_data=0.
  - Buffer contents are not cleared.
  - Reset during LOAD aborts the load; no further writes occur.
- Transfer: a beat is accepted at an edge where bias_valid && ready.
  - With ready=0, bias_data and bias_last are ignored and nothing is written.
- IDLE state:
  - ready=0.
  - load_start → LOAD; word_cnt, bias_done and len_err are cleared on that edge.
- LOAD state:
  - ready=1, decoded directly from state; no added latency.
  - Each transfer writes bias_data[DATA_W-1:0] to entry 2*word_cnt and the upper half to entry 2*word_cnt+1, then increments word_cnt.
  - Transfer with bias_last=1 and word_cnt==CH_NUM/2-1: go to DONE, len_err stays 0.
  - Transfer with bias_last=1 and word_cnt<CH_NUM/2-1 (early last): that beat is written, len_err=1, go to DONE.
  - Transfer with bias_last=0 and word_cnt==CH_NUM/2-1 (missing last): that beat is written, len_err=1, go to DONE. Any beats after that see ready=0 and are dropped.
  - load_start is ignored in LOAD.
  - Gaps in bias_valid are allowed; state is held.
- DONE state:
  - bias_done=1, ready=0.
  - load_start → LOAD (reload for the next layer); bias_done and len_err drop on that edge.
- Timing: ready is 0 in the cycle after the final accepted beat. bias_done rises in that same cycle.
- Read port:
  - Active in every state.
  - rd_en at edge N gives rd_data = buf[rd_addr] and rd_valid=1 after edge N.
  - rd_valid=0 in any cycle following rd_en=0.
  - rd_data holds its last value when rd_en=0.
  - Read and write of the same entry at the same edge return the old contents (read-before-write).
  - rd_addr >= CH_NUM returns 0 with rd_valid=1.
- Widths: biases are stored bit-exact with no sign manipulation. word_cnt is ADDR_W bits and never wraps, since LOAD exits at CH_NUM/2-1.

Test Plan:
- Nominal load:
  - Stimulus: load_start, then 128 back-to-back beats. Beat k = {b[2k+1], b[2k]}, with b[0]=1369, b[1]=66, b[254]=1000, b[255]=-1242; last on beat 127.
  - Required: bias_done=1, len_err=0, ready=0 one cycle after beat 127. Reads of addresses 0, 1, 254, 255 return 0x00000559, 0x00000042, 0x000003E8, 0xFFFFFB26, each with 1-cycle latency.
- Throttled source:
  - Stimulus: bias_valid toggles 1/0 every cycle over the full 128 beats.
  - Required: same buffer contents as nominal; bias_done only after the 128th accepted beat.
- Early last:
  - Stimulus: bias_last on beat 9.
  - Required: entries 0..19 written, len_err=1, bias_done=1. A later beat with a distinct value is not written (entry 20 unchanged).
- Missing last:
  - Stimulus: 130 beats, bias_last never asserted.
  - Required: len_err=1 after beat 127. Beats 128 and 129 are dropped (ready=0). Entry 255 holds the beat-127 upper half.
- Reset mid-load:
  - Stimulus: s_rst after 50 beats.
  - Required: next cycle ready=0, bias_done=0, state IDLE; entries 100..255 keep their prior values.
  - Then a full reload gives correct data.
- Reload and read-during-write:
  - Stimulus: from DONE, load_start. Then read addr 0 at the same edge as beat 0 writes a new value of 7.
  - Required: rd_data returns the old value 1369. The next read of addr 0 returns 7. bias_done and len_err dropped at load_start.
